// File: rtl/fire8_expand3_writeback.sv
// Fire8 expand3 write-back: captures one pixel's DSP_NO channel words per sample
// and drains them, one word per cycle, into the expand3 slice of the concatenated RAM.
module fire8_expand3_writeback #(
  parameter int WOUT      = 8,
  parameter int DSP_NO    = 256,
  parameter int WIDTH     = 16,
  parameter int CH_TOTAL  = 512,
  parameter int CH_OFFSET = 256,
  parameter int ADDR_W    = $clog2(WOUT * WOUT * CH_TOTAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire8_expand3_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              ram_feedback,
  output logic              overrun_err
);

  localparam int PIXELS = WOUT * WOUT;
  localparam int CH_W   = $clog2(DSP_NO);
  localparam int PIX_W  = $clog2(PIXELS + 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  buffer [0:DSP_NO-1];
  logic [CH_W-1:0]   ch_idx, ch_inc;
  logic [PIX_W-1:0]  pix_idx, pix_next;
  logic              load, advance, overrun, last_ch, last_pix, pix_done;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    overrun    = 1'b0;
    last_ch    = (ch_idx == CH_LAST);
    last_pix   = (pix_idx == PIX_LAST);
    pix_done   = (state == DRAIN) && last_ch;
    ch_inc     = ch_idx + 1'b1;
    pix_next   = pix_done ? pix_idx + 1'b1 : pix_idx;
    case (state)
      IDLE: begin
        if (fire8_expand3_sample) begin
          load       = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_ch) begin
          if (fire8_expand3_sample && !last_pix) begin
            load = 1'b1;
          end else begin
            overrun    = fire8_expand3_sample;
            state_next = last_pix ? DONE : IDLE;
          end
        end else begin
          advance = 1'b1;
          overrun = fire8_expand3_sample;
        end
      end
      DONE:    ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Channels of a pixel occupy consecutive addresses, so after the base is
  // loaded the address just counts up alongside ch_idx.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_idx      <= '0;
      pix_idx     <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (load) begin
        ch_idx  <= '0;
        wr_data <= ofm[0];
        wr_addr <= ADDR_W'(pix_next) * ADDR_W'(CH_TOTAL) + ADDR_W'(CH_OFFSET);
      end else if (advance) begin
        ch_idx  <= ch_inc;
        wr_data <= buffer[ch_inc];
        wr_addr <= wr_addr + 1'b1;
      end else if (pix_done) begin
        ch_idx  <= '0;
      end
      if (pix_done) pix_idx <= pix_next;
      if (overrun)  overrun_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) buffer <= ofm;
  end

  assign wr_en        = (state == DRAIN);
  assign busy         = (state == DRAIN);
  assign ram_feedback = (state == DONE);

endmodule

// File: tb/tb_fire8_expand3_writeback.sv
// Directed bench for fire8_expand3_writeback: single pixel, back-to-back,
// overrun, mid-drain reset, full 64-pixel layer and samples after completion.
module tb_fire8_expand3_writeback;

  localparam int WOUT = 8, DSP_NO = 256, WIDTH = 16, CH_TOTAL = 512, CH_OFFSET = 256;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              wr_en, busy, ram_feedback, overrun_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  fire8_expand3_writeback #(
    .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH),
    .CH_TOTAL(CH_TOTAL), .CH_OFFSET(CH_OFFSET), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .fire8_expand3_sample(sample), .ofm(ofm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .ram_feedback(ram_feedback), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_total  = wr_total + 1;
      last_addr = wr_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ofm(input int base);
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(base + i);
  endtask

  task automatic pulse();
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Checks the 256 writes of one pixel; optionally raises a sample at channel inj_at.
  task automatic expect_pixel(input int pix, input int dbase, input int inj_at, input int inj_base);
    for (int c = 0; c < DSP_NO; c++) begin
      check("wr_en", 32'(wr_en), 32'd1);
      check("wr_addr", 32'(wr_addr), 32'(pix * CH_TOTAL + CH_OFFSET + c));
      check("wr_data", 32'(wr_data), 32'(dbase + c));
      if (c == inj_at) begin
        set_ofm(inj_base);
        pulse();
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    int base;
    rst = 1'b0;
    sample = 1'b0;
    set_ofm(1);
    #3;
    tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_feedback", 32'(ram_feedback), 32'd0);
    check("rst_overrun", 32'(overrun_err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b1;

    // single pixel, sampled at the first edge after reset release
    pulse();
    expect_pixel(0, 1, -1, 0);
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_wr_en_after", 32'(wr_en), 32'd0);
    check("single_overrun", 32'(overrun_err), 32'd0);

    // back-to-back: second sample coincides with the ch 255 write
    do_reset();
    set_ofm(1);
    pulse();
    expect_pixel(0, 1, DSP_NO - 1, 1000);
    expect_pixel(1, 1000, -1, 0);
    check("b2b_busy_after", 32'(busy), 32'd0);
    check("b2b_overrun", 32'(overrun_err), 32'd0);

    // overrun at ch 10: data unchanged, flag sticky, next pixel is pixel 1
    do_reset();
    set_ofm(1);
    pulse();
    expect_pixel(0, 1, 10, 5000);
    check("ovr_flag", 32'(overrun_err), 32'd1);
    tick();
    tick();
    check("ovr_sticky", 32'(overrun_err), 32'd1);
    set_ofm(7);
    pulse();
    expect_pixel(1, 7, -1, 0);
    check("ovr_sticky2", 32'(overrun_err), 32'd1);

    // reset in the middle of a drain
    do_reset();
    check("rst_clears_overrun", 32'(overrun_err), 32'd0);
    set_ofm(1);
    pulse();
    for (int i = 0; i < 100; i++) tick();
    check("mid_addr_ch100", 32'(wr_addr), 32'(CH_OFFSET + 100));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    tick();
    rst = 1'b1;
    set_ofm(300);
    pulse();
    expect_pixel(0, 300, -1, 0);

    // full layer, 64 samples spaced 1009 cycles
    do_reset();
    base = wr_total;
    for (int p = 0; p < WOUT * WOUT; p++) begin
      set_ofm(p * 300);
      pulse();
      expect_pixel(p, p * 300, -1, 0);
      if (p == WOUT * WOUT - 1) begin
        check("layer_feedback", 32'(ram_feedback), 32'd1);
        check("layer_busy_done", 32'(busy), 32'd0);
      end else begin
        check("layer_feedback_early", 32'(ram_feedback), 32'd0);
        for (int i = 0; i < 1009 - DSP_NO - 1; i++) tick();
      end
    end
    check("layer_writes", 32'(wr_total - base), 32'd16384);
    check("layer_last_addr", 32'(last_addr), 32'd32767);
    check("layer_overrun", 32'(overrun_err), 32'd0);

    // samples in DONE are ignored
    base = wr_total;
    set_ofm(9);
    pulse();
    check("done_wr_en", 32'(wr_en), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("done_no_writes", 32'(wr_total - base), 32'd0);
    check("done_feedback", 32'(ram_feedback), 32'd1);
    check("done_overrun", 32'(overrun_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire8_expand3_writeback.md
FIRE8_EXPAND3_WRITEBACK -- requirements
Module: fire8_expand3_writeback

Interface
REQ-001 Parameter WOUT, default 8, output feature-map side; the layer produces WOUT**2 pixels.
REQ-002 Parameter DSP_NO, default 256, number of parallel channel words per sample.
REQ-003 Parameter WIDTH, default 16, channel word width.
REQ-004 Parameter CH_TOTAL, default 512, channels per pixel in the concatenated fire8 output RAM.
REQ-005 Parameter CH_OFFSET, default 256, first channel slot owned by expand3 within CH_TOTAL.
REQ-006 Parameter ADDR_W, default $clog2(WOUT**2*CH_TOTAL) (15), RAM address width.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 fire8_expand3_sample  input  1  one-cycle strobe; ofm valid and stable during this cycle.
REQ-010 ofm  input  DSP_NO x WIDTH (unpacked array [0:DSP_NO-1])  per-channel activations, already ReLU'd and quantised.
REQ-011 wr_en  output  1  RAM write strobe.
REQ-012 wr_addr  output  ADDR_W  RAM word address.
REQ-013 wr_data  output  WIDTH  RAM write data.
REQ-014 busy  output  1  high while the capture buffer is draining.
REQ-015 ram_feedback  output  1  high once all WOUT**2 pixels are written; drives upstream ram_feedback.
REQ-016 overrun_err  output  1  sticky flag; sample arrived while the buffer was unavailable.

Function
REQ-017 FSM states SHALL be IDLE, DRAIN and DONE; the reset state SHALL be IDLE.
REQ-018 In IDLE, a sample high at a rising edge SHALL load all DSP_NO ofm words into the capture buffer at that edge, clear ch_idx to 0, and enter DRAIN.
REQ-019 In DRAIN, each cycle SHALL assert wr_en=1 with wr_data=buffer[ch_idx] and wr_addr=pix_idx*CH_TOTAL+CH_OFFSET+ch_idx, then increment ch_idx.
REQ-020 Latency: first write (ch 0) SHALL be in the cycle after the capture edge; the last write (ch DSP_NO-1) SHALL be DSP_NO-1 cycles later.
REQ-021 When DRAIN writes ch_idx=DSP_NO-1, pix_idx SHALL increment; the next state SHALL be DONE if pix_idx was WOUT**2-1, otherwise IDLE.
REQ-022 Back-to-back case: a sample coincident with the ch DSP_NO-1 write SHALL be accepted if that pixel is not the last; the buffer reloads, ch_idx returns to 0, and the state stays DRAIN with no idle cycle.
REQ-023 A sample during DRAIN at any other ch_idx SHALL be ignored, SHALL NOT alter the buffer or counters, and SHALL set overrun_err.
REQ-024 In DONE, ram_feedback SHALL be 1, wr_en SHALL be 0, and samples SHALL be ignored without setting overrun_err; DONE SHALL persist until reset.
REQ-025 busy SHALL equal (state==DRAIN); wr_en SHALL be 0 in IDLE and DONE.
REQ-026 Address arithmetic SHALL be unsigned ADDR_W bits; with default parameters the maximum address SHALL be 63*512+256+255=32767, with no wrap.
REQ-027 wr_data and wr_addr SHALL be registered outputs, with no combinational path from ofm or the sample input.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, ch_idx=0, pix_idx=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, ram_feedback=0, overrun_err=0; buffer contents are don't-care.
REQ-029 Reset asserted mid-DRAIN SHALL abort the pixel with no further writes; after release, the block SHALL accept the next sample as pixel 0.
REQ-030 The first sample SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-031 Single pixel: ofm[i]=i+1, one sample -> 256 consecutive wr_en cycles, addr 256..511, data 1..256, then busy=0.
REQ-032 Full layer: 64 samples spaced 1009 cycles -> 16384 writes; last write addr 32767; ram_feedback=1 the cycle after; overrun_err=0.
REQ-033 Back-to-back: second sample coincident with the ch 255 write of pixel 0 -> pixel 1 writes start next cycle at addr 768; no gap; overrun_err=0.
REQ-034 Overrun: sample at ch_idx=10 -> overrun_err=1 sticky; pixel-0 data and addresses unchanged; pix_idx still 1 after the drain.
REQ-035 Reset mid-DRAIN at ch_idx=100 -> wr_en=0 immediately; a sample after release writes from addr 256 again.
REQ-036 Sample in DONE -> no wr_en, ram_feedback stays 1, overrun_err stays 0.
